mux_arbiter: RTL and testbench
==============================

Name: mux_arbiter

Overview:
- Two-requester round-robin arbiter that shares one output channel through a 2:1 multiplexer.
- Requesters present a level request plus data. The arbiter picks one per cycle, captures its word into a registered output stage and drives a valid/ready handshake downstream.
- It also exports the mux select `s`, using the codebase convention: s=1 selects in1, s=0 selects in2.

Parameters:
- WIDTH, 8: data width of in1, in2 and out.
- BURST, 2: maximum consecutive grants to one requester while the other is requesting (≥1).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- req1  input  1  requester 1 has a word on in1.
- in1  input  WIDTH  requester 1 data.
- ack1  output  1  in1 captured this cycle.
- req2  input  1  requester 2 has a word on in2.
- in2  input  WIDTH  requester 2 data.
- ack2  output  1  in2 captured this cycle.
- out  output  WIDTH  registered output word.
- out_valid  output  1  out holds a word not yet accepted.
- out_ready  input  1  downstream accepts out this cycle.
- s  output  1  registered select of the word in out: 1 = in1, 0 = in2.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: reset_n sampled low at a rising clock edge resets the block.
- Reset values: out=0, out_valid=0, s=0, ack1=ack2=0, state=IDLE, last grant=2 (so in1 wins the first contest), burst_cnt=0.
- Reset mid-transfer discards the held word; no ack is produced in the reset cycle.
- States:
  - IDLE: out_valid=0.
  - BUSY: out_valid=1.
- Load condition: load = !out_valid || out_ready. A capture happens when load and (req1 || req2).
- On capture at a clock edge:
  - out ← selected input; s ← 1 for in1, 0 for in2.
  - out_valid ← 1; state ← BUSY.
- Transitions:
  - BUSY with out_ready=1 and no request → IDLE, out_valid ← 0; out keeps its last value.
  - BUSY with out_ready=0 → hold out, s, out_valid; assert no ack.
- Ack timing:
  - ack1/ack2 are combinational, asserted in the cycle whose closing edge captures that requester's data.
  - At most one ack is high per cycle.
  - Requesters hold req and data stable until they see ack high at an edge; they may present the next word in the following cycle.
- Throughput: back-to-back transfers of one word per cycle while out_ready=1. Latency from req (idle, out_ready=1) to out_valid is 1 cycle.
- Selection when both request:
  - If the last grantee requests and burst_cnt < BURST → grant it again, burst_cnt+1.
  - Otherwise grant the other requester, burst_cnt ← 1.
- Selection when only one requests: grant it. burst_cnt+1 if it is the same grantee (saturating at BURST), else 1. The arbiter is work-conserving: a lone requester is never stalled by BURST.
- Widths: burst_cnt is wide enough to hold BURST. No arithmetic on data; out is a pure select of in1/in2.
- req without load (out_valid=1, out_ready=0): no ack and no state change; arbitration is re-evaluated every cycle.

Test Plan:
- Reset: hold reset_n=0 for 2 edges with req1=req2=1 → out=0, out_valid=0, s=0, ack1=ack2=0; first edge after release captures in1 (ack1=1).
- Single requester: req1=1, in1=8'hA5, out_ready=1 → ack1 high that cycle; next cycle out=8'hA5, out_valid=1, s=1; drop req1 → out_valid=0 after acceptance.
- Burst/round-robin, BURST=2, both requesting continuously, in1=8'h11, in2=8'h22, out_ready=1 → s sequence 1,1,0,0,1,1…; out alternates 11,11,22,22 each cycle.
- Backpressure: capture in2=8'h3C, then out_ready=0 for 3 cycles with req1=1 → out=8'h3C, s=0, out_valid=1 held, ack1=0; out_ready=1 → in1 captured in that cycle.
- Lone requester beyond BURST: only req2 for 5 words, BURST=2 → 5 consecutive captures, s=0 each, no idle cycles.
- Reset mid-BUSY: out_valid=1, out_ready=0, reset_n=0 one edge → out_valid=0, out=0, s=0; next arbitration favours in1.

Source files
------------

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter feeding one registered output word through a 2:1 mux.
// Valid/ready: a word transfers downstream on any rising edge where out_valid && out_ready.
module mux_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req1,
  input  logic [WIDTH-1:0] in1,
  output logic             ack1,
  input  logic             req2,
  input  logic [WIDTH-1:0] in2,
  output logic             ack2,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s,
  output logic [0:0]       state
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  logic          last1;      // 1: last grant went to in1
  logic [CW-1:0] burst_cnt;
  logic          load;
  logic          grant;
  logic          pick1;
  logic          repeat_ok;
  logic [CW-1:0] cnt_next;

  assign out_valid = (state == BUSY);
  assign load      = !out_valid || out_ready;
  assign grant     = reset_n && load && (req1 || req2);

  // burst_cnt==0 means no burst in progress, so the other side wins the first contest.
  assign repeat_ok = (burst_cnt != '0) && (burst_cnt < BURST_C);

  always_comb begin
    pick1 = req1;
    if (req1 && req2) begin
      pick1 = last1 ? repeat_ok : !repeat_ok;
    end
  end

  always_comb begin
    cnt_next = CW'(1);
    if (pick1 == last1) begin
      cnt_next = (burst_cnt < BURST_C) ? burst_cnt + CW'(1) : burst_cnt;
    end
  end

  assign ack1 = grant && pick1;
  assign ack2 = grant && !pick1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out       <= '0;
      s         <= 1'b0;
      state     <= IDLE;
      last1     <= 1'b0;
      burst_cnt <= '0;
    end else if (grant) begin
      out       <= pick1 ? in1 : in2;
      s         <= pick1;
      state     <= BUSY;
      last1     <= pick1;
      burst_cnt <= cnt_next;
    end else if (out_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: reset, round-robin bursts, backpressure, lone requester, reset mid-transfer.
module tb_mux_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req1, req2;
  logic [7:0] in1, in2;
  logic       ack1, ack2;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       s;
  logic [0:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mux_arbiter #(.WIDTH(8), .BURST(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req1(req1), .in1(in1), .ack1(ack1),
    .req2(req2), .in2(in2), .ack2(ack2),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic sel, input logic v);
    check({tag, ".out"}, 32'(out), 32'(d));
    check({tag, ".s"}, 32'(s), 32'(sel));
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".state"}, 32'(state), 32'(v));
  endtask

  task automatic check_ack(input string tag, input logic a1, input logic a2);
    @(negedge clock);
    check({tag, ".ack1"}, 32'(ack1), 32'(a1));
    check({tag, ".ack2"}, 32'(ack2), 32'(a2));
  endtask

  initial begin
    reset_n = 1'b0; req1 = 1'b1; req2 = 1'b1;
    in1 = 8'h11; in2 = 8'h22; out_ready = 1'b1;

    // reset held for two edges with both requesting
    tick(); tick();
    check_ack("rst", 1'b0, 1'b0);
    check_out("rst", 8'h00, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;

    // both requesting: s pattern 1,1,0,0,1,1
    for (int i = 0; i < 6; i++) begin
      logic e1;
      e1 = ((i / 2) % 2) == 0;
      check_ack($sformatf("rr%0d", i), e1, !e1);
      tick();
      check_out($sformatf("rr%0d", i), e1 ? 8'h11 : 8'h22, e1, 1'b1);
    end

    // single requester, then drain
    req2 = 1'b0; in1 = 8'hA5;
    check_ack("single", 1'b1, 1'b0);
    tick();
    check_out("single", 8'hA5, 1'b1, 1'b1);
    req1 = 1'b0;
    check_ack("drain", 1'b0, 1'b0);
    tick();
    check_out("drain", 8'hA5, 1'b1, 1'b0);

    // backpressure holds in2 word while req1 waits
    req2 = 1'b1; in2 = 8'h3C;
    check_ack("bp_cap", 1'b0, 1'b1);
    tick();
    check_out("bp_cap", 8'h3C, 1'b0, 1'b1);
    req2 = 1'b0; req1 = 1'b1; in1 = 8'h5A; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_ack($sformatf("bp%0d", i), 1'b0, 1'b0);
      tick();
      check_out($sformatf("bp%0d", i), 8'h3C, 1'b0, 1'b1);
    end
    out_ready = 1'b1;
    check_ack("bp_rel", 1'b1, 1'b0);
    tick();
    check_out("bp_rel", 8'h5A, 1'b1, 1'b1);
    req1 = 1'b0;

    // lone requester beyond BURST: no stalls
    req2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in2 = 8'h40 + 8'(i);
      check_ack($sformatf("lone%0d", i), 1'b0, 1'b1);
      tick();
      check_out($sformatf("lone%0d", i), 8'h40 + 8'(i), 1'b0, 1'b1);
    end
    req2 = 1'b0;
    check_ack("lone_end", 1'b0, 1'b0);
    tick();
    check_out("lone_end", 8'h44, 1'b0, 1'b0);

    // reset while BUSY and stalled
    req2 = 1'b1; in2 = 8'h77;
    check_ack("mr_cap", 1'b0, 1'b1);
    tick();
    check_out("mr_cap", 8'h77, 1'b0, 1'b1);
    out_ready = 1'b0; req1 = 1'b1; in1 = 8'h11; reset_n = 1'b0;
    check_ack("mr_rst", 1'b0, 1'b0);
    tick();
    check_out("mr_rst", 8'h00, 1'b0, 1'b0);
    reset_n = 1'b1; out_ready = 1'b1;
    check_ack("mr_after", 1'b1, 1'b0);
    tick();
    check_out("mr_after", 8'h11, 1'b1, 1'b1);

    req1 = 1'b0; req2 = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
